// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner FSM state type and key-code width helper
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, CONFIRM, HELD} kp_state_t;
  function automatic int kw_of(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction
endpackage

// File: rtl/keypad_tick_gen.sv
// tick_gen: divides clk by DIV into a one-cycle tick pulse (in: clk, rst; out: tick)
module tick_gen #(
  parameter int DIV = 65536
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk) cnt <= rst || tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: debounced matrix-keypad scanner (in: clk, rst, fila rows, key_ack; out: col strobe, key_code, key_valid, key_pressed, key_overrun)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int CLK_DIV = 65536,
  parameter int DEBOUNCE = 4,
  localparam int KW = kw_of(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] fila,
  output logic [COLS-1:0] col,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ack,
  output logic            key_pressed,
  output logic            key_overrun
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  logic tick, confirm;
  logic [ROWS-1:0] s1, fs;
  kp_state_t state, state_n;
  logic [CW-1:0] ci, ci_n, ci_inc;
  logic [RW-1:0] ri, ri_n, low;
  logic [3:0] cnt, cnt_n, cnt_inc;
  logic [KW-1:0] code_n;
  tick_gen #(.DIV(CLK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  assign ci_inc = ci == CW'(COLS - 1) ? '0 : ci + CW'(1);
  assign cnt_inc = cnt + 4'd1;
  assign col = COLS'(1) << ci;
  assign key_pressed = state == HELD;
  assign code_n = KW'(int'(ri_n) * COLS + int'(ci));
  always_comb begin
    low = '0;
    for (int i = ROWS - 1; i >= 0; i--) if (fs[i]) low = RW'(i);
  end
  always_comb begin
    state_n = state;
    ci_n = ci;
    ri_n = ri;
    cnt_n = cnt;
    confirm = 1'b0;
    if (tick)
      case (state)
        SCAN:
          if (fs == '0) ci_n = ci_inc;
          else begin
            ri_n = low;
            confirm = DEBOUNCE == 1;
            cnt_n = confirm ? 4'd0 : 4'd1;
            state_n = confirm ? HELD : CONFIRM;
          end
        CONFIRM:
          if (!fs[ri]) begin
            ci_n = ci_inc;
            cnt_n = '0;
            state_n = SCAN;
          end else begin
            confirm = cnt_inc == 4'(DEBOUNCE);
            cnt_n = confirm ? 4'd0 : cnt_inc;
            state_n = confirm ? HELD : CONFIRM;
          end
        HELD:
          if (fs[ri]) cnt_n = '0;
          else if (cnt_inc == 4'(DEBOUNCE)) begin
            ci_n = ci_inc;
            cnt_n = '0;
            state_n = SCAN;
          end else cnt_n = cnt_inc;
        default: state_n = SCAN;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      fs <= '0;
      state <= SCAN;
      ci <= '0;
      ri <= '0;
      cnt <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
      key_overrun <= 1'b0;
    end else begin
      s1 <= fila;
      fs <= s1;
      state <= state_n;
      ci <= ci_n;
      ri <= ri_n;
      cnt <= cnt_n;
      key_overrun <= confirm && key_valid && !key_ack;
      if (confirm && (!key_valid || key_ack)) key_code <= code_n;
      key_valid <= confirm || (key_valid && !key_ack);
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and random keypad presses checked against a tick-level keypad model
module tb_keypad_scanner;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int CLK_DIV = 4;
  localparam int DEBOUNCE = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_ack = 1'b0;
  logic [ROWS-1:0] fila;
  logic [COLS-1:0] col;
  logic [3:0] key_code;
  logic key_valid, key_pressed, key_overrun;
  logic [15:0] keys = '0;
  int checks = 0;
  int errors = 0;
  int ovr_seen = 0;
  int tc = 0, mcol = 0, mrow = -1, streak = 0, rel = 0, mcode = 0;
  bit mvalid = 0, movr = 0, mheld = 0;
  logic [ROWS-1:0] h1 = '0, h2 = '0;
  keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst), .fila(fila), .col(col), .key_code(key_code), .key_valid(key_valid),
    .key_ack(key_ack), .key_pressed(key_pressed), .key_overrun(key_overrun)
  );
  always #5 clk = ~clk;
  always_comb begin
    fila = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && col[c]) fila[r] = 1'b1;
  end
  always @(posedge clk) begin
    bit conf;
    logic [ROWS-1:0] fs;
    conf = 0;
    fs = h2;
    if (rst) begin
      tc = 0; mcol = 0; mrow = -1; streak = 0; rel = 0; mcode = 0;
      mvalid = 0; movr = 0; mheld = 0; h1 = '0; h2 = '0;
    end else begin
      if (tc == CLK_DIV - 1) begin
        if (mheld) begin
          rel = fs[mrow] ? 0 : rel + 1;
          if (rel == DEBOUNCE) begin
            mheld = 0; mrow = -1; mcol = (mcol + 1) % COLS;
          end
        end else if (mrow < 0) begin
          if (fs == 0) mcol = (mcol + 1) % COLS;
          else begin
            for (int r = ROWS - 1; r >= 0; r--) if (fs[r]) mrow = r;
            streak = 1;
          end
        end else if (fs[mrow]) streak++;
        else begin
          mrow = -1; mcol = (mcol + 1) % COLS;
        end
        if (!mheld && mrow >= 0 && streak == DEBOUNCE) begin
          conf = 1; mheld = 1; rel = 0; streak = 0;
        end
      end
      movr = conf && mvalid && !key_ack;
      if (conf && (!mvalid || key_ack)) begin
        mcode = mrow * COLS + mcol; mvalid = 1;
      end else if (!conf && key_ack) mvalid = 0;
      h2 = h1; h1 = fila; tc = (tc + 1) % CLK_DIV;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (key_overrun === 1'b1) ovr_seen++;
      check("m_col", 32'(col), 32'(1) << mcol);
      check("m_code", 32'(key_code), 32'(mcode));
      check("m_valid", 32'(key_valid), 32'(mvalid));
      check("m_pressed", 32'(key_pressed), 32'(mheld));
      check("m_overrun", 32'(key_overrun), 32'(movr));
    end
  endtask
  task automatic wait_for(input int sel, input string tag);
    bit hit;
    hit = 0;
    for (int n = 0; n < 400 && !hit; n++) begin
      cyc(1);
      case (sel)
        0: hit = key_valid;
        1: hit = key_pressed;
        2: hit = !key_pressed;
        3: hit = col == 4'b1000;
        4: hit = mrow >= 0 && !mheld;
        default: hit = mrow >= 0 && !mheld && streak == DEBOUNCE - 1 && tc == CLK_DIV - 1;
      endcase
    end
    if (!hit) check({tag, "_timeout"}, 0, 1);
  endtask
  task automatic ack_pulse();
    key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, 32'(col), 1);
    check({tag, "_code"}, 32'(key_code), 0);
    check({tag, "_valid"}, 32'(key_valid), 0);
    check({tag, "_pressed"}, 32'(key_pressed), 0);
    check({tag, "_overrun"}, 32'(key_overrun), 0);
  endtask
  initial begin
    int ovr0;
    cyc(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      cyc(CLK_DIV);
      check("idle_col", 32'(col), 32'(1) << ((t + 1) % COLS));
    end
    check("idle_valid", 32'(key_valid), 0);
    check("idle_pressed", 32'(key_pressed), 0);
    keys[9] = 1'b1;
    cyc(10 * CLK_DIV);
    check("k9_code", 32'(key_code), 9);
    check("k9_valid", 32'(key_valid), 1);
    check("k9_pressed", 32'(key_pressed), 1);
    check("k9_col", 32'(col), 4'b0010);
    keys = '0;
    wait_for(2, "k9_release");
    check("k9_resume_col", 32'(col), 4'b0100);
    ack_pulse();
    check("k9_ack_valid", 32'(key_valid), 0);
    wait_for(3, "glitch_col3");
    keys[3] = 1'b1;
    cyc(CLK_DIV);
    keys = '0;
    cyc(CLK_DIV);
    check("glitch_col_adv", 32'(col), 4'b0001);
    cyc(4 * CLK_DIV);
    check("glitch_valid", 32'(key_valid), 0);
    check("glitch_pressed", 32'(key_pressed), 0);
    keys[0] = 1'b1;
    wait_for(0, "k0_confirm");
    check("k0_code", 32'(key_code), 0);
    keys = '0;
    wait_for(2, "k0_release");
    ovr0 = ovr_seen;
    keys[15] = 1'b1;
    wait_for(1, "k15_press");
    cyc(2);
    check("ovr_code", 32'(key_code), 0);
    check("ovr_valid", 32'(key_valid), 1);
    check("ovr_pulses", 32'(ovr_seen - ovr0), 1);
    ack_pulse();
    check("ovr_ack_valid", 32'(key_valid), 0);
    keys = '0;
    wait_for(2, "k15_release");
    keys[15] = 1'b1;
    wait_for(0, "k15_again");
    check("k15_code", 32'(key_code), 15);
    ack_pulse();
    keys = '0;
    wait_for(2, "k15_release2");
    keys[5] = 1'b1;
    wait_for(0, "k5_confirm");
    check("k5_code", 32'(key_code), 5);
    keys = '0;
    wait_for(2, "k5_release");
    ovr0 = ovr_seen;
    keys[6] = 1'b1;
    wait_for(5, "k6_imminent");
    ack_pulse();
    check("same_cycle_valid", 32'(key_valid), 1);
    check("same_cycle_code", 32'(key_code), 6);
    check("same_cycle_overrun", 32'(ovr_seen - ovr0), 0);
    check("same_cycle_pressed", 32'(key_pressed), 1);
    keys = '0;
    wait_for(2, "k6_release");
    ack_pulse();
    keys[10] = 1'b1;
    wait_for(4, "rst_confirm_wait");
    rst = 1'b1;
    cyc(1);
    check_reset_outputs("rst_confirm");
    keys = '0;
    rst = 1'b0;
    cyc(6 * CLK_DIV);
    check("rst_confirm_noevent", 32'(key_valid), 0);
    keys[10] = 1'b1;
    wait_for(1, "rst_held_wait");
    rst = 1'b1;
    cyc(1);
    check_reset_outputs("rst_held");
    keys = '0;
    rst = 1'b0;
    cyc(6 * CLK_DIV);
    check("rst_held_noevent", 32'(key_valid), 0);
    check("rst_held_pressed", 32'(key_pressed), 0);
    for (int it = 0; it < 25; it++) begin
      int hold, gap;
      keys = 16'(1) << $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) keys = keys | (16'(1) << $urandom_range(0, 15));
      hold = $urandom_range(1, 10) * CLK_DIV;
      gap = $urandom_range(1, 6) * CLK_DIV;
      for (int k = 0; k < hold + gap; k++) begin
        if (k == hold) keys = '0;
        key_ack = $urandom_range(0, 3) == 0;
        cyc(1);
      end
    end
    key_ack = 1'b0;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner that drives one-hot column strobes, samples the row lines, debounces a single key and hands each confirmed press to the consumer through a valid/ack register. It replaces the fixed 4x4, free-running, un-debounced scanner in the input path and sits between the keypad pins and the operation/control logic. It adds a programmable scan rate, press/release debounce, a held-key level and overrun reporting.

## Interface
- `ROWS`, 4: number of row inputs (2..8).
- `COLS`, 4: number of column strobes (2..8).
- `CLK_DIV`, 65536: `clk` cycles per scan tick (≥2).
- `DEBOUNCE`, 4: consecutive ticks a level must hold to confirm a press or release (1..15).
- `KW`, `$clog2(ROWS*COLS)`: key-code width (derived, not overridden).

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `fila`, in, `ROWS`: row lines, active-high, asynchronous to `clk`.
- `col`, out, `COLS`: one-hot column strobe.
- `key_code`, out, `KW`: code of the last confirmed key, equal to row_index*COLS + col_index.
- `key_valid`, out, 1: a confirmed press is pending. Held until acknowledged.
- `key_ack`, in, 1: consumer accepts the pending code.
- `key_pressed`, out, 1: a confirmed key is currently held down.
- `key_overrun`, out, 1: one-cycle pulse when a press is dropped because `key_valid` was still set.

## Operation
- `fila` passes through a 2-flop synchroniser. All decisions use the synchronised value `fs`.
- A tick counter counts 0..CLK_DIV-1. `tick` is asserted for one `clk` cycle when the counter wraps. All FSM activity is on `tick` cycles only.
- The column index `ci` selects the strobe, so `col` = 1<<ci. Rows are sampled on the tick that ends the column period.
- SCAN state:
  - If `fs` is 0 on a tick, `ci` advances, wrapping COLS-1→0.
  - Otherwise, capture `ri` = lowest set bit of `fs`, freeze `ci`, set cnt=1 and go to CONFIRM.
- CONFIRM state, on each tick:
  - If `fs[ri]` is 1, increment cnt. When cnt reaches DEBOUNCE, load `key_code`, start the handshake, set cnt=0 and go to HELD.
  - If `fs[ri]` is 0, return to SCAN with `ci` advanced.
  - With DEBOUNCE=1, the capture tick confirms directly: SCAN goes straight to HELD and the event is emitted.
- HELD state, `ci` frozen, on each tick:
  - If `fs[ri]` is 0, increment cnt. If `fs[ri]` is 1, set cnt=0.
  - When cnt reaches DEBOUNCE, go to SCAN with `ci` advanced.
- `key_pressed` = (state == HELD).
- Handshake:
  - A confirmed press with `key_valid` = 0 loads `key_code` and sets `key_valid`.
  - `key_ack` while `key_valid` is set clears it.
  - Confirm while `key_valid` is set and no `key_ack`: keep the old code, drop the new one and pulse `key_overrun`.
  - Confirm and `key_ack` in the same cycle: load the new code and keep `key_valid` at 1, with no overrun.
- Multiple keys:
  - Several rows in one column: the lowest row wins.
  - Keys in other columns are ignored until the held key is released.
- Reset mid-operation discards any candidate and any pending event.

## Timing
- Reset values:
  - `col` = 1 (column 0), `key_code` = 0, `key_valid` = 0, `key_pressed` = 0, `key_overrun` = 0.
  - state SCAN, tick counter 0, cnt 0, synchroniser flops 0.
- `key_valid`, `key_code` and `key_pressed` update on the `clk` edge of the confirming tick. They are registered outputs.
- Press latency from a stable `fila` edge: 2 clk (sync) + up to COLS ticks (scan) + (DEBOUNCE-1) ticks.
- `col` changes only on tick cycles.
- `key_ack` is sampled every `clk` cycle, not only on ticks.
- `key_ack` with `key_valid` = 0 is ignored.

## Structure
- Package `keypad_pkg` holds:
  - the state enum `kp_state_t` {SCAN, CONFIRM, HELD};
  - the localparam helper for KW.
- Sub-module `tick_gen` (parameter DIV; ports `clk`, `rst`, `tick`) is the divider. The synchroniser and FSM stay inline.

## Test plan
Bench parameters: ROWS=4, COLS=4, CLK_DIV=4, DEBOUNCE=3.
- Reset, then idle for 20 ticks: `col` cycles 0001→0010→0100→1000→0001, with `key_valid` and `key_pressed` at 0.
- Hold row 2 while col 1 is strobed for 10 ticks: `key_code` = 9, `key_valid` = 1 after 3 ticks of confirmation, `key_pressed` = 1, `col` frozen at 0010. Release for 3 ticks: `key_pressed` = 0 and scanning resumes at col 2.
- A 1-tick glitch on row 0 in col 3: no `key_valid`, and the scan continues.
- Confirm key 0, no ack, then confirm key 15: `key_code` stays 0 and `key_overrun` pulses once. Ack, then press key 15 again: `key_code` = 15.
- Assert `key_ack` on the exact cycle a new key 6 confirms while key 5 is pending: `key_valid` stays 1, `key_code` = 6, no overrun.
- Assert `rst` during CONFIRM and during HELD: all outputs return to reset values on the next edge, and no event is emitted.
